// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and default datapath sizing.
package alu_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH:0]   next_rem,
   output logic [WIDTH-1:0] next_quo
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // One guard bit above the partial remainder so its MSB takes part in the sign test.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {2'b00, dsr};
      if (!diff[WIDTH+1]) begin
         next_rem = diff[WIDTH:0];
         next_quo = {quo[WIDTH-2:0], 1'b1};
      end else begin
         next_rem = shifted[WIDTH:0];
         next_quo = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV32_SIGNED_EN to add the sgn port for two's-complement (truncating) division.
module div32_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
   input  logic             sgn,
`endif
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   div_state_t       state;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dsr_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             q_neg;
   logic             r_neg;
   logic             qneg_q;
   logic             rneg_q;

`ifdef DIV32_SIGNED_EN
   always_comb begin
      q_neg = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg = sgn & dividend[WIDTH-1];
      a_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
      b_mag = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
   end
`else
   always_comb begin
      q_neg = 1'b0;
      r_neg = 1'b0;
      a_mag = dividend;
      b_mag = divisor;
   end
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dsr      (dsr_q),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         cnt       <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     // Zero divisor bypasses RUN; FIN publishes these raw values uncorrected.
                     quo_q    <= '1;
                     rem_q    <= {1'b0, dividend};
                     qneg_q   <= 1'b0;
                     rneg_q   <= 1'b0;
                     div_zero <= 1'b1;
                     state    <= FIN;
                  end else begin
                     quo_q    <= a_mag;
                     dsr_q    <= b_mag;
                     rem_q    <= '0;
                     cnt      <= '0;
                     qneg_q   <= q_neg;
                     rneg_q   <= r_neg;
                     div_zero <= 1'b0;
                     busy     <= 1'b1;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt   <= cnt + 1'b1;
               if (cnt == '1) begin
                  busy  <= 1'b0;
                  state <= FIN;
               end
            end
            FIN: begin
               quotient  <= qneg_q ? -quo_q : quo_q;
               remainder <= rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
               done      <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: vector table, ignored-start and reset sequences, random ops vs a reference model.
module tb_div32_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          busy;
   logic          done;
   logic          div_zero;
`ifdef DIV32_SIGNED_EN
   logic          sgn;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   div32_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef DIV32_SIGNED_EN
      .sgn       (sgn),
`endif
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands, truncating signed division.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic dz, output int lat);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 0) begin
         q = '1; r = a; dz = 1'b1; lat = 1;
      end else begin
         dz  = 1'b0;
         lat = W + 1;
         if (!s) begin
            q = a / b;
            r = a % b;
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end
   endfunction

   // Inputs driven on negedge; outputs sampled on the negedge after each active edge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int elat, input bit pulses, input string nm);
      int first = 0;
      int ndone = 0;
      int nbusy = 0;
      logic [W-1:0] gq = 'x;
      logic [W-1:0] gr = 'x;
      logic         gdz = 1'bx;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
`ifdef DIV32_SIGNED_EN
      sgn = s;
`else
      if (s) $display("note: signed vector %s run without signed support", nm);
`endif
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      if (busy) nbusy++;
      for (int k = 1; k <= elat + 3; k++) begin
         if (pulses && (k == 10 || k == elat)) begin
            start = 1'b1; dividend = 50; divisor = 5;
         end
         @(negedge clk);
         start = 1'b0;
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (first == 0) begin
               first = k; gq = quotient; gr = remainder; gdz = div_zero;
            end
         end
      end
      chk($sformatf("%s.latency", nm), first, elat);
      chk($sformatf("%s.done_count", nm), ndone, 1);
      chk($sformatf("%s.busy_cycles", nm), nbusy, (elat == 1) ? 0 : W);
      chk($sformatf("%s.quotient", nm), gq, eq);
      chk($sformatf("%s.remainder", nm), gr, er);
      chk($sformatf("%s.div_zero", nm), {31'b0, gdz}, {31'b0, edz});
      chk($sformatf("%s.q_hold", nm), quotient, eq);
   endtask

   vec_t tbl[$];

   initial begin
      logic [W-1:0] ra, rb, eq, er;
      logic         rs, edz;
      int           elat, ndone;

      tbl.push_back('{a: 100,           b: 7,             s: 0, q: 14,            r: 2, dz: 0, lat: 33});
      tbl.push_back('{a: 32'hFFFF_FFFF, b: 1,             s: 0, q: 32'hFFFF_FFFF, r: 0, dz: 0, lat: 33});
      tbl.push_back('{a: 3,             b: 32'h8000_0000, s: 0, q: 0,             r: 3, dz: 0, lat: 33});
      tbl.push_back('{a: 5,             b: 0,             s: 0, q: 32'hFFFF_FFFF, r: 5, dz: 1, lat: 1});
      tbl.push_back('{a: 9,             b: 3,             s: 0, q: 3,             r: 0, dz: 0, lat: 33});
      tbl.push_back('{a: 7,             b: 32'h0000_0008, s: 0, q: 0,             r: 7, dz: 0, lat: 33});
`ifdef DIV32_SIGNED_EN
      tbl.push_back('{a: 32'hFFFF_FFF9, b: 2,             s: 1, q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 0, lat: 33});
      tbl.push_back('{a: 7,             b: 32'hFFFF_FFFE, s: 1, q: 32'hFFFF_FFFD, r: 1,             dz: 0, lat: 33});
      tbl.push_back('{a: 32'h8000_0000, b: 32'hFFFF_FFFF, s: 1, q: 32'h8000_0000, r: 0,             dz: 0, lat: 33});
      tbl.push_back('{a: 32'hFFFF_FFFB, b: 0,             s: 1, q: 32'hFFFF_FFFF, r: 32'hFFFF_FFFB, dz: 1, lat: 1});
      sgn = 1'b0;
`endif

      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("reset.quotient", quotient, '0);
      chk("reset.remainder", remainder, '0);
      chk("reset.busy", {31'b0, busy}, '0);
      chk("reset.done", {31'b0, done}, '0);
      chk("reset.div_zero", {31'b0, div_zero}, '0);
      reset = 1'b0;

      foreach (tbl[i])
         do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat, 1'b0,
               $sformatf("vec%0d", i));

      // Starts during RUN and during FIN must be dropped.
      do_op(100, 7, 1'b0, 14, 2, 1'b0, 33, 1'b1, "ignore_start");

      // Reset in the middle of RUN aborts with no done pulse.
      @(negedge clk);
      start = 1'b1; dividend = 1000; divisor = 3;
`ifdef DIV32_SIGNED_EN
      sgn = 1'b0;
`endif
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.busy", {31'b0, busy}, '0);
      chk("abort.quotient", quotient, '0);
      chk("abort.remainder", remainder, '0);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort.no_done", ndone, 0);
      do_op(1000, 3, 1'b0, 333, 1, 1'b0, 33, 1'b0, "after_abort");

      for (int n = 0; n < 24; n++) begin
         int sel;
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         rb  = (sel == 0) ? '0 : (sel < 5) ? W'($urandom_range(1, 255)) : $urandom;
`ifdef DIV32_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         ref_div(ra, rb, rs, eq, er, edz, elat);
         do_op(ra, rb, rs, eq, er, edz, elat, 1'b0, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
